// File: rtl/fifo_uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
// Optional even-parity bit is enabled by defining FIFO_UART_TX_PARITY_EN.
package fifo_uart_pkg;

   // Defaults shared with the synchronous FIFO so both ends agree on word size
   localparam int unsigned DEFAULT_WIDTH        = 8;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LATCH  = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// pre_tick flags the cycle just before the terminal count so registered
// consumers can line up a pulse with the last cycle of a bit.
module uart_baud_cnt
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick,
   output logic pre_tick
);

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [CNT_WIDTH-1:0] PRE_CNT  = CNT_WIDTH'(CLKS_PER_BIT - 2);

   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;

   // Next count: restart on clear or after the terminal count
   always_comb begin
      cnt_nxt = cnt + CNT_WIDTH'(1);
      if (clear || (cnt == LAST_CNT)) begin
         cnt_nxt = '0;
      end
   end

   // Count register with flags decoded from the next count so they are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         tick     <= 1'b0;
         pre_tick <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         tick     <= (cnt_nxt == LAST_CNT);
         pre_tick <= (cnt_nxt == PRE_CNT);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame through the FIFO
// read port and sends start, WIDTH data bits LSB first, optional even parity
// (macro FIFO_UART_TX_PARITY_EN), and one stop bit on tx.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned WIDTH        = DEFAULT_WIDTH,
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_r_data,
   input  logic             fifo_rd_error,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             tx_done,
   output logic             underflow_err
);

   localparam int unsigned       IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [IDX_W-1:0] bit_idx;
   logic [IDX_W-1:0] bit_idx_nxt;
   logic             tx_nxt;
   logic             rd_en_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             baud_clear;
   logic             tick;
   logic             pre_tick;
   logic             rd_en_d;
`ifdef FIFO_UART_TX_PARITY_EN
   logic             par;
   logic             par_nxt;
`endif

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_WIDTH    (CNT_WIDTH)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (baud_clear),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: FETCH/LATCH are single cycles, serial bits advance on tick
   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (!fifo_empty) next_state = FETCH;
         FETCH: next_state = LATCH;
         LATCH: next_state = START;
         START: if (tick) next_state = DATA;
         DATA: begin
            if (tick && (bit_idx == LAST_IDX)) begin
`ifdef FIFO_UART_TX_PARITY_EN
               next_state = PARITY;
`else
               next_state = STOP;
`endif
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: if (tick) next_state = STOP;
`endif
         STOP: begin
            if (tick) begin
               next_state = fifo_empty ? IDLE : FETCH;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output/datapath next values; tx follows the state being entered
   always_comb begin
      shreg_nxt   = shreg;
      bit_idx_nxt = bit_idx;
      rd_en_nxt   = (next_state == FETCH);
      busy_nxt    = (next_state != IDLE);
      done_nxt    = (state == STOP) && pre_tick;
      baud_clear  = (state == LATCH);
`ifdef FIFO_UART_TX_PARITY_EN
      par_nxt     = par;
`endif

      if (state == LATCH) begin
         shreg_nxt   = fifo_r_data;
         bit_idx_nxt = '0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_nxt     = ^fifo_r_data;
`endif
      end else if ((state == DATA) && tick) begin
         shreg_nxt   = shreg >> 1;
         bit_idx_nxt = (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
      end

      tx_nxt = 1'b1;
      case (next_state)
         START:  tx_nxt = 1'b0;
         DATA:   tx_nxt = shreg_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: tx_nxt = par_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         tx         <= 1'b1;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
         shreg      <= '0;
         bit_idx    <= '0;
         rd_en_d    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         tx         <= tx_nxt;
         fifo_rd_en <= rd_en_nxt;
         busy       <= busy_nxt;
         tx_done    <= done_nxt;
         shreg      <= shreg_nxt;
         bit_idx    <= bit_idx_nxt;
         rd_en_d    <= fifo_rd_en;
`ifdef FIFO_UART_TX_PARITY_EN
         par        <= par_nxt;
`endif
      end
   end

   // Sticky underflow: FIFO error reported in the cycle after our read pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         underflow_err <= 1'b0;
      end else if (rd_en_d && fifo_rd_error) begin
         underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a queue-based FIFO model and a
// frame-level reference model (set FIFO_UART_TX_PARITY_EN for the parity build).
module tb_fifo_uart_tx;

   localparam int unsigned W   = 8;
   localparam int unsigned CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int unsigned FB  = W + 3;
`else
   localparam int unsigned FB  = W + 2;
`endif
   localparam int unsigned FLEN = FB * CPB;
   localparam int unsigned MAXC = 512;

   logic         clk = 1'b0;
   logic         rst;
   logic         fifo_empty;
   logic [W-1:0] fifo_r_data;
   logic         fifo_rd_error;
   logic         fifo_rd_en;
   logic         tx;
   logic         busy;
   logic         tx_done;
   logic         underflow_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] fq[$];
   bit           inject_err = 1'b0;
   bit           pend_err;

   logic exp_tx   [MAXC];
   logic exp_rd   [MAXC];
   logic exp_done [MAXC];
   logic exp_busy [MAXC];

   typedef struct {
      logic [W-1:0] data;
      logic [9:0]   frame10;   // bit0 = start, bits 1..8 = data LSB first, bit9 = stop
      logic         par;
   } vec_t;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .WIDTH        (W),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty    (fifo_empty),
      .fifo_r_data   (fifo_r_data),
      .fifo_rd_error (fifo_rd_error),
      .fifo_rd_en    (fifo_rd_en),
      .tx            (tx),
      .busy          (busy),
      .tx_done       (tx_done),
      .underflow_err (underflow_err)
   );

   // FIFO model: responds just after each rising edge; error flag lags the pop by one cycle
   initial begin
      fifo_empty    = 1'b1;
      fifo_r_data   = '0;
      fifo_rd_error = 1'b0;
      pend_err      = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         fifo_rd_error = pend_err;
         pend_err      = 1'b0;
         if (fifo_rd_en === 1'b1) begin
            if (fq.size() > 0) begin
               fifo_r_data = fq.pop_front();
               pend_err    = inject_err;
            end else begin
               pend_err = 1'b1;
            end
         end
         fifo_empty = (fq.size() == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic add_exp(inout int n, input logic t, input logic r, input logic d, input logic b);
      exp_tx[n]   = t;
      exp_rd[n]   = r;
      exp_done[n] = d;
      exp_busy[n] = b;
      n++;
   endtask

   // Reference: one idle sample, then per word FETCH, LATCH, FB bits of CPB cycles, then idle tail
   task automatic build_exp(input logic [W-1:0] words[$], output int n);
      logic bits [FB];
      n = 0;
      add_exp(n, 1'b1, 1'b0, 1'b0, 1'b0);
      foreach (words[j]) begin
         add_exp(n, 1'b1, 1'b1, 1'b0, 1'b1);
         add_exp(n, 1'b1, 1'b0, 1'b0, 1'b1);
         bits[0] = 1'b0;
         for (int i = 0; i < int'(W); i++) bits[i+1] = words[j][i];
`ifdef FIFO_UART_TX_PARITY_EN
         bits[W+1] = ^words[j];
`endif
         bits[FB-1] = 1'b1;
         for (int k = 0; k < int'(FB); k++)
            for (int c = 0; c < int'(CPB); c++)
               add_exp(n, bits[k], 1'b0, (k == int'(FB) - 1) && (c == int'(CPB) - 1), 1'b1);
      end
      for (int i = 0; i < 4; i++) add_exp(n, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Push a burst (called just after a falling edge) and compare every cycle to the model
   task automatic run_burst(input string name, input logic [W-1:0] words[$], output int rd_cnt);
      int n;
      int bad;
      int first;
      build_exp(words, n);
      foreach (words[j]) fq.push_back(words[j]);
      bad    = 0;
      first  = -1;
      rd_cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (fifo_rd_en === 1'b1) rd_cnt++;
         if ({tx, fifo_rd_en, tx_done, busy} !== {exp_tx[i], exp_rd[i], exp_done[i], exp_busy[i]}) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: %0d cycles differ, first at cycle %0d (tx/rd/done/busy got %b%b%b%b expected %b%b%b%b)",
                  name, bad, first, tx, fifo_rd_en, tx_done, busy,
                  exp_tx[first], exp_rd[first], exp_done[first], exp_busy[first]);
      end
   endtask

   // Single word: sample the middle of each bit and locate the tx_done pulse
   task automatic run_vec(input vec_t v, input int id);
      logic       got [FB];
      logic [9:0] got10;
      int         rd_cnt = 0;
      int         done_cnt = 0;
      int         done_idx = -1;
      int         b;
      fq.push_back(v.data);
      for (int idx = 0; idx <= 2 + int'(FLEN) + 3; idx++) begin
         @(negedge clk);
         if (fifo_rd_en === 1'b1) rd_cnt++;
         if (tx_done === 1'b1) begin
            done_cnt++;
            done_idx = idx;
         end
         if (idx >= 3) begin
            b = (idx - 3) / int'(CPB);
            if ((b < int'(FB)) && (((idx - 3) % int'(CPB)) == int'(CPB) / 2)) got[b] = tx;
         end
      end
      got10[0] = got[0];
      for (int i = 1; i <= int'(W); i++) got10[i] = got[i];
      got10[9] = got[FB-1];
      check($sformatf("vec%0d_frame", id), 32'(got10), 32'(v.frame10));
`ifdef FIFO_UART_TX_PARITY_EN
      check($sformatf("vec%0d_parity", id), 32'(got[W+1]), 32'(v.par));
`endif
      check($sformatf("vec%0d_rd_pulses", id), 32'(rd_cnt), 32'd1);
      check($sformatf("vec%0d_done_count", id), 32'(done_cnt), 32'd1);
      check($sformatf("vec%0d_done_cycle", id), 32'(done_idx), 32'(2 + FLEN));
      check($sformatf("vec%0d_idle_after", id), 32'({busy, tx}), 32'b01);
   endtask

   initial begin
      vec_t         vecs [7];
      logic [W-1:0] words[$];
      int           rd_cnt;
      int           cnt_a;
      int           cnt_b;
      int           cnt_c;

      vecs[0] = '{data: 8'hA5, frame10: 10'b1101001010, par: 1'b0};
      vecs[1] = '{data: 8'h07, frame10: 10'b1000001110, par: 1'b1};
      vecs[2] = '{data: 8'h03, frame10: 10'b1000000110, par: 1'b0};
      vecs[3] = '{data: 8'h00, frame10: 10'b1000000000, par: 1'b0};
      vecs[4] = '{data: 8'hFF, frame10: 10'b1111111110, par: 1'b0};
      vecs[5] = '{data: 8'h3C, frame10: 10'b1001111000, par: 1'b0};
      vecs[6] = '{data: 8'h80, frame10: 10'b1100000000, par: 1'b1};

      // Reset and idle
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({tx, busy, fifo_rd_en, tx_done, underflow_err}), 32'b10000);
      rst = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fifo_rd_en !== 1'b0) cnt_a++;
         if (tx !== 1'b1 || busy !== 1'b0) cnt_b++;
      end
      check("idle_no_rd_en", 32'(cnt_a), 32'd0);
      check("idle_line_high", 32'(cnt_b), 32'd0);

      // Table-driven single frames
      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Back-to-back burst
      words = '{8'h00, 8'hFF, 8'h3C};
      run_burst("b2b_trace", words, rd_cnt);
      check("b2b_rd_pulses", 32'(rd_cnt), 32'd3);
      check("b2b_fifo_empty", 32'(fq.size()), 32'd0);
      check("b2b_underflow", 32'(underflow_err), 32'd0);

      // Randomized bursts against the reference model
      for (int r = 0; r < 8; r++) begin
         words = {};
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) words.push_back(W'($urandom));
         run_burst($sformatf("rand%0d_trace", r), words, rd_cnt);
         check($sformatf("rand%0d_rd_pulses", r), 32'(rd_cnt), 32'(words.size()));
      end

      // Reset in the middle of data bit 3 (0x52 has bit3 = 0)
      fq.push_back(8'h52);
      for (int i = 0; i <= 3 + 4 * int'(CPB) + 1; i++) @(negedge clk);
      check("midrst_bit3_before", 32'({busy, tx}), 32'b10);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_after_edge", 32'({tx, busy, tx_done}), 32'b100);
      rst = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      cnt_c = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx_done !== 1'b0) cnt_a++;
         if (fifo_rd_en !== 1'b0) cnt_b++;
         if (tx !== 1'b1) cnt_c++;
      end
      check("midrst_no_done", 32'(cnt_a), 32'd0);
      check("midrst_no_reread", 32'(cnt_b), 32'd0);
      check("midrst_line_idle", 32'(cnt_c), 32'd0);
      words = '{8'hC3};
      run_burst("midrst_next_word", words, rd_cnt);

      // Underflow flag: sticky until reset
      check("uf_clear_before", 32'(underflow_err), 32'd0);
      inject_err = 1'b1;
      words = '{8'h96};
      run_burst("uf_trace", words, rd_cnt);
      inject_err = 1'b0;
      check("uf_set", 32'(underflow_err), 32'd1);
      repeat (30) @(negedge clk);
      check("uf_sticky", 32'(underflow_err), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("uf_cleared_by_rst", 32'(underflow_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
